// File: rtl/atctlc2axi500_tl_defs.sv
// -----------------------------------------------------------------------------
// atctlc2axi500_tl_defs
// Shared TileLink-C definitions for the TL-C to AXI bridge. The manager-side
// sink ID pool and the client-side GrantAck generator both import this package,
// so the D opcodes and the sink width stay consistent on both ends.
//   TL_D_GRANT         : D opcode for Grant
//   TL_D_GRANT_DATA    : D opcode for GrantData
//   TL_SINK_WIDTH_DFLT : default width of d_sink / e_sink
// -----------------------------------------------------------------------------
package atctlc2axi500_tl_defs;

  localparam logic [2:0] TL_D_GRANT      = 3'd4;
  localparam logic [2:0] TL_D_GRANT_DATA = 3'd5;

  localparam int TL_SINK_WIDTH_DFLT = 3;

endpackage : atctlc2axi500_tl_defs

// File: rtl/atctlc2axi500_ack_fifo.sv
// -----------------------------------------------------------------------------
// atctlc2axi500_ack_fifo
// WIDTH x DEPTH register FIFO with wrap-bit pointers. The head entry is read
// straight out of the register array (no output staging), so o_rd_data is
// valid in the same cycle o_empty goes low and holds until the head is popped.
// Writes while full and reads while empty are ignored.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   i_wr_en     : push request
//   i_wr_data   : push data
//   i_rd_en     : pop request
//   o_rd_data   : head entry
//   o_full      : DEPTH entries stored
//   o_empty     : no entries stored
// -----------------------------------------------------------------------------
module atctlc2axi500_ack_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr_fire;
  logic             w_rd_fire;

  // Same index with opposite wrap bits means the writer is a full lap ahead.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_wr_fire = i_wr_en & ~o_full;
  assign w_rd_fire = i_rd_en & ~o_empty;
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer and storage update; a dropped write leaves everything unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr_fire) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        r_wr_ptr                <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd_fire) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

endmodule : atctlc2axi500_ack_fifo

// File: rtl/atctlc2axi500_bin2onehot.sv
// -----------------------------------------------------------------------------
// atctlc2axi500_bin2onehot
// Binary to one-hot decoder with an enable. All outputs are zero when the
// enable is low, so the result can be OR-ed/masked into a bitmap directly.
// Ports:
//   i_en     : decode enable
//   i_bin    : binary index, IN_W bits
//   o_onehot : one-hot vector, 2**IN_W bits
// -----------------------------------------------------------------------------
module atctlc2axi500_bin2onehot #(
  parameter int IN_W = 3
) (
  input  logic                   i_en,
  input  logic [IN_W-1:0]        i_bin,
  output logic [(1<<IN_W)-1:0]   o_onehot
);

  // Decode the index into a single set bit, gated by the enable.
  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_bin] = 1'b1;
    end else begin
      o_onehot = '0;
    end
  end

endmodule : atctlc2axi500_bin2onehot

// File: rtl/atctlc2axi500_grant_ack_gen.sv
// -----------------------------------------------------------------------------
// atctlc2axi500_grant_ack_gen
// Client-side GrantAck generator. Every accepted Grant/GrantData last beat
// queues its d_sink; the queue head is offered on the E channel as a GrantAck,
// in arrival order. A pending-sink bitmap flags a sink granted again while its
// ack is still outstanding; that, and any enqueue attempted while the queue is
// full, sets the sticky dup_err.
// Ports:
//   clk, resetn        : clock, asynchronous active-low reset
//   d_valid, d_ready   : D-channel handshake as seen at the client
//   d_opcode, d_last   : D opcode and last-beat marker
//   d_sink             : sink ID of the D message
//   d_stall            : ack queue full, client must stall Grant last beats
//   e_valid, e_ready   : E-channel GrantAck handshake
//   e_sink             : sink ID carried by the GrantAck
//   dup_err            : sticky duplicate/overflow flag
// -----------------------------------------------------------------------------
module atctlc2axi500_grant_ack_gen
  import atctlc2axi500_tl_defs::*;
#(
  parameter int SINK_WIDTH = TL_SINK_WIDTH_DFLT,
  parameter int ACK_DEPTH  = 2**SINK_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  d_valid,
  input  logic                  d_ready,
  input  logic [2:0]            d_opcode,
  input  logic                  d_last,
  input  logic [SINK_WIDTH-1:0] d_sink,
  output logic                  d_stall,
  output logic                  e_valid,
  input  logic                  e_ready,
  output logic [SINK_WIDTH-1:0] e_sink,
  output logic                  dup_err
);

  localparam int NSINK = 2**SINK_WIDTH;

  logic                  w_is_grant;
  logic                  w_enq;
  logic                  w_enq_accept;
  logic                  w_deq;
  logic                  w_full;
  logic                  w_empty;
  logic [SINK_WIDTH-1:0] w_head;
  logic [NSINK-1:0]      w_set_oh;
  logic [NSINK-1:0]      w_clr_oh;
  logic                  w_same_sink_turnover;
  logic                  w_dup_hit;
  logic [NSINK-1:0]      r_pending;
  logic                  r_dup_err;

  assign w_is_grant   = (d_opcode == TL_D_GRANT) | (d_opcode == TL_D_GRANT_DATA);
  assign w_enq        = d_valid & d_ready & d_last & w_is_grant;
  assign w_enq_accept = w_enq & ~w_full;
  assign w_deq        = ~w_empty & e_ready;

  atctlc2axi500_ack_fifo #(
    .WIDTH (SINK_WIDTH),
    .DEPTH (ACK_DEPTH)
  ) u_ack_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .i_wr_en   (w_enq),
    .i_wr_data (d_sink),
    .i_rd_en   (e_ready),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Only a write that actually lands in the queue marks its sink pending,
  // otherwise a dropped overflow write would leave a bit nothing ever clears.
  atctlc2axi500_bin2onehot #(
    .IN_W (SINK_WIDTH)
  ) u_set_dec (
    .i_en     (w_enq_accept),
    .i_bin    (d_sink),
    .o_onehot (w_set_oh)
  );

  atctlc2axi500_bin2onehot #(
    .IN_W (SINK_WIDTH)
  ) u_clr_dec (
    .i_en     (w_deq),
    .i_bin    (w_head),
    .o_onehot (w_clr_oh)
  );

  // The head being acked this cycle with the same sink being re-granted is a
  // legal hand-over: the old pending bit is retired as the new one is set.
  assign w_same_sink_turnover = w_deq & (w_head == d_sink);
  assign w_dup_hit = w_enq & (w_full | (r_pending[d_sink] & ~w_same_sink_turnover));

  // Pending bitmap: clear retires the old entry, set then marks the new one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr_oh) | w_set_oh;
    end
  end

  // Sticky protocol-violation flag, cleared only by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dup_err <= 1'b0;
    end else if (w_dup_hit) begin
      r_dup_err <= 1'b1;
    end else begin
      r_dup_err <= r_dup_err;
    end
  end

  assign e_valid = ~w_empty;
  assign e_sink  = w_head;
  assign d_stall = w_full;
  assign dup_err = r_dup_err;

endmodule : atctlc2axi500_grant_ack_gen

// File: tb/tb_atctlc2axi500_grant_ack_gen.sv
module tb_atctlc2axi500_grant_ack_gen;

  localparam int SW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          d_valid;
  logic          d_ready;
  logic [2:0]    d_opcode;
  logic          d_last;
  logic [SW-1:0] d_sink;
  logic          d_stall;
  logic          e_valid;
  logic          e_ready;
  logic [SW-1:0] e_sink;
  logic          dup_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: ordered list of outstanding acks plus the sticky flag.
  int q[$];
  bit m_dup;

  atctlc2axi500_grant_ack_gen #(
    .SINK_WIDTH (SW),
    .ACK_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .d_opcode (d_opcode),
    .d_last   (d_last),
    .d_sink   (d_sink),
    .d_stall  (d_stall),
    .e_valid  (e_valid),
    .e_ready  (e_ready),
    .e_sink   (e_sink),
    .dup_err  (dup_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/e_valid"}, {31'd0, e_valid}, (q.size() != 0) ? 32'd1 : 32'd0);
    if (q.size() != 0) chk({tag, "/e_sink"}, {29'd0, e_sink}, q[0]);
    chk({tag, "/d_stall"}, {31'd0, d_stall}, (q.size() == DEPTH) ? 32'd1 : 32'd0);
    chk({tag, "/dup_err"}, {31'd0, dup_err}, {31'd0, m_dup});
  endtask

  // Apply the rules of one clock edge to the model, using the held inputs.
  task automatic model_edge(input bit v, input bit r, input bit l, input int op,
                            input int sink, input bit er);
    bit enq;
    bit deq;
    bit full;
    int cnt;
    enq  = v && r && l && (op == 4 || op == 5);
    deq  = (q.size() > 0) && er;
    full = (q.size() == DEPTH);
    cnt  = 0;
    for (int i = (deq ? 1 : 0); i < q.size(); i++) if (q[i] == sink) cnt++;
    if (enq && (full || cnt > 0)) m_dup = 1'b1;
    if (deq) void'(q.pop_front());
    if (enq && !full) q.push_back(sink);
  endtask

  // One clock: drive after the falling edge, update model at the rising edge,
  // check outputs at the next falling edge.
  task automatic cyc(input string tag, input bit v, input bit r, input bit l,
                     input int op, input int sink, input bit er);
    d_valid  = v;
    d_ready  = r;
    d_last   = l;
    d_opcode = op[2:0];
    d_sink   = sink[SW-1:0];
    e_ready  = er;
    @(posedge clk);
    model_edge(v, r, l, op, sink, er);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    d_valid = 1'b0; d_ready = 1'b0; d_last = 1'b0; d_opcode = 3'd0; d_sink = '0; e_ready = 1'b0;
    q.delete();
    m_dup = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int v, r, l, op, sk, er;
    do_reset();
    check_all("reset");

    // Single Grant, sink 5, acked immediately
    cyc("single", 1, 1, 1, 4, 5, 1);
    cyc("single_ack", 0, 0, 0, 0, 0, 1);
    cyc("single_idle", 0, 0, 0, 0, 0, 1);

    // Four-beat GrantData to sink 2
    for (int i = 0; i < 3; i++) cyc("gd_beat", 1, 1, 0, 5, 2, 1);
    cyc("gd_last", 1, 1, 1, 5, 2, 1);
    cyc("gd_ack", 0, 0, 0, 0, 0, 1);
    cyc("gd_idle", 0, 0, 0, 0, 0, 1);

    // Filtering: AccessAck, ReleaseAck, non-accepted Grant on sink 1
    cyc("filt_aack", 1, 1, 1, 0, 1, 0);
    cyc("filt_rack", 1, 1, 1, 6, 1, 0);
    cyc("filt_nrdy", 1, 0, 1, 4, 1, 0);
    cyc("filt_grant", 1, 1, 1, 4, 1, 0);
    cyc("filt_drain", 0, 0, 0, 0, 0, 1);

    // Fill with sinks 0..7 under backpressure, then drain in order
    for (int i = 0; i < DEPTH; i++) cyc("fill", 1, 1, 1, 4, i, 0);
    for (int i = 0; i < DEPTH + 1; i++) cyc("drain", 0, 0, 0, 0, 0, 1);

    // Duplicate sink 3 while pending
    cyc("dup_first", 1, 1, 1, 4, 3, 0);
    cyc("dup_second", 1, 1, 1, 5, 3, 0);
    for (int i = 0; i < 3; i++) cyc("dup_drain", 0, 0, 0, 0, 0, 1);

    // Same-cycle hand-over of sink 3 is not a duplicate
    do_reset();
    check_all("reset2");
    cyc("turn_first", 1, 1, 1, 4, 3, 0);
    cyc("turn_swap", 1, 1, 1, 4, 3, 1);
    cyc("turn_drain", 0, 0, 0, 0, 0, 1);
    cyc("turn_idle", 0, 0, 0, 0, 0, 1);

    // Fill, overflow, then asynchronous reset mid-queue
    for (int i = 0; i < DEPTH; i++) cyc("ofl_fill", 1, 1, 1, 4, i, 0);
    cyc("ofl_drop", 1, 1, 1, 4, 6, 0);
    d_valid = 1'b0; e_ready = 1'b1;
    #2 resetn = 1'b0;
    #1;
    chk("async_rst/e_valid", {31'd0, e_valid}, 32'd0);
    chk("async_rst/d_stall", {31'd0, d_stall}, 32'd0);
    chk("async_rst/dup_err", {31'd0, dup_err}, 32'd0);
    q.delete();
    m_dup = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) cyc("post_rst", 0, 0, 0, 0, 0, 1);

    // Randomized traffic, client obeying d_stall
    for (int n = 0; n < 600; n++) begin
      v  = int'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 3) != 0);
      l  = int'($urandom_range(0, 3) != 0);
      op = int'($urandom_range(0, 7));
      sk = int'($urandom_range(0, 7));
      er = int'($urandom_range(0, 2) != 0);
      if (d_stall && l != 0 && (op == 4 || op == 5)) r = 0;
      cyc("rand", v[0], r[0], l[0], op, sk, er[0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_atctlc2axi500_grant_ack_gen

// File: doc/atctlc2axi500_grant_ack_gen.md
# atctlc2axi500_grant_ack_gen

Client-end counterpart of the sink ID pool in the TileLink-C to AXI bridge. The block watches accepted D-channel Grant/GrantData responses and captures each message's `d_sink` on its last beat. It queues these sinks and issues one E-channel GrantAck per Grant, in arrival order, carrying that sink back to the manager-side pool. It also flags protocol violations: a sink granted twice while its ack is still pending.

## Interface
- `SINK_WIDTH`, default 3: width of `d_sink` and `e_sink`. Must match the manager-side pool.
- `ACK_DEPTH`, default 2**SINK_WIDTH: ack queue entries. Power of two, ≥2.
- `clk`  in  1  clock. Single clock domain.
- `resetn`  in  1  reset. Asynchronous assert, active-low.
- `d_valid`  in  1  D-channel valid, as seen at the client.
- `d_ready`  in  1  D-channel ready, as driven by the client. A beat is accepted when `d_valid & d_ready`.
- `d_opcode`  in  3  D-channel opcode.
- `d_last`  in  1  last beat of the current D message.
- `d_sink`  in  SINK_WIDTH  sink ID of the current D message.
- `d_stall`  out  1  queue full. The client must hold `d_ready` low for Grant/GrantData last beats while this is high.
- `e_valid`  out  1  GrantAck valid.
- `e_ready`  in  1  GrantAck ready.
- `e_sink`  out  SINK_WIDTH  sink ID returned with the GrantAck.
- `dup_err`  out  1  sticky: a sink was enqueued while the same sink was already pending.

## Operation
- Enqueue condition (`enq`): `d_valid & d_ready & d_last` and `d_opcode` is GRANT (3'd4) or GRANT_DATA (3'd5).
  - All other opcodes are ignored.
  - Non-last GrantData beats are ignored.
- On `enq`, `d_sink` is written at `wr_ptr`, `wr_ptr` increments, and `pending[d_sink]` is set.
- Dequeue condition (`deq`): `e_valid & e_ready`. On `deq`, `rd_ptr` increments and `pending[e_sink]` is cleared.
- Pointers are log2(ACK_DEPTH)+1 bits wide, with wrap bit.
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
- `e_valid` = !empty. `e_sink` = entry at `rd_ptr`, driven from the register array with no extra staging.
- `d_stall` = full.
  - If `enq` occurs while full, the write is dropped and `dup_err` is set; this is overflow, reported on the same flag.
  - Pointers and the queue are unchanged by a dropped write.
- Duplicate check: `enq` with `pending[d_sink]` already set sets `dup_err`. The entry is still enqueued.
- Once set, `dup_err` stays high until reset.
- Simultaneous `enq` and `deq` on a non-full queue: both take effect and count is unchanged.
- Simultaneous `enq` and `deq` on the same sink: the clear applies to the old entry and the set to the new one. Net result: `pending` stays 1 and no `dup_err`.
- Reset values: `e_valid`=0, `e_sink`=0, `d_stall`=0, `dup_err`=0, `pending`=0, both pointers 0.
- Reset mid-operation discards all queued acks. Pending sinks are lost; the manager side is reset in the same domain.

## Timing
- GrantAck latency: `e_valid` rises the cycle after the `enq` edge. There is no same-cycle bypass.
- Throughput: one enqueue and one dequeue per cycle sustained.
- Once `e_valid` is high, `e_sink` holds stable until `deq`.
- `d_stall` is registered-state derived. It goes high the cycle after the filling `enq` and low the cycle after the freeing `deq`.
- `dup_err` rises the cycle after the offending `enq`.

## Structure
- Shared package / include `atctlc2axi500_tl_defs` holds:
  - D opcode constants `TL_D_GRANT`=3'd4 and `TL_D_GRANT_DATA`=3'd5.
  - The sink-width default.
  - The manager-side pool uses the same constants.
- One sub-module, `atctlc2axi500_ack_fifo`: a parameterized WIDTH×DEPTH register FIFO with wrap-bit pointers and full/empty outputs.
- Pending bitmap decode reuses the codebase's `atctlc2axi500_bin2onehot`.

## Test plan
- **Single Grant:** Grant, d_sink=5, d_last=1, accepted at cycle N, `e_ready`=1.
  - Required: `e_valid`=1 with `e_sink`=5 at N+1 only, then idle.
- **Multi-beat GrantData:** 4 beats, sink=2, last beat accepted at N.
  - Required: exactly one ack, `e_valid` from N+1, `e_sink`=2.
  - Required: no ack for beats 1–3.
- **Filtering:** AccessAck, ReleaseAck and a non-accepted (`d_ready`=0) Grant.
  - Required: no `e_valid` and no change to `pending`.
- **Fill / backpressure:** `e_ready`=0, 8 Grants with sinks 0–7.
  - Required: `d_stall`=1 after the 8th.
  - Then `e_ready`=1: acks emerge in order 0..7, `d_stall` drops one cycle after the first `deq`, and `dup_err` stays 0.
- **Duplicate:** Grant sink=3 queued, ack not yet taken, second Grant sink=3.
  - Required: `dup_err`=1 next cycle and both acks delivered.
  - Same-cycle deq of 3 with enq of 3: `dup_err` stays 0.
- **Reset mid-queue:** 3 acks pending, `resetn` pulsed low asynchronously.
  - Required: `e_valid`, `d_stall` and `dup_err` go to 0 immediately, and no stale ack appears after reset.
